tdc_fine_pattern_gen: RTL and testbench

- Decoder-direction counterpart of the TDC fine encoder.
- Converts a 5-bit fine code plus run-length "level" into the 32-tap delay-line phase pattern the fine encoder consumes.
- Operates in single-shot or full-sweep mode, with dwell control.
- Sits in the TDC test/calibration path, driving the fine encoder input in place of the delay line, with an aligned expected-code output for self-check.

---
 rtl/tdc_fine_pattern_gen_pkg.sv | 22 ++
 rtl/tdc_fine_pattern_gen_if.sv | 44 ++++
 rtl/tdc_fine_pattern_gen_run_decoder.sv | 28 ++
 rtl/tdc_fine_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_tdc_fine_pattern_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_fine_pattern_gen_pkg.sv
// rtl/tdc_fine_pattern_gen_pkg.sv - shared widths, mode encodings and FSM state type for the fine pattern generator
// Contents: CODE_W/PAT_W code and pattern widths, LEVEL_MIN/LEVEL_MAX legal run lengths,
//           MODE_* encodings of the 2-bit mode input, patgen_state_e FSM states.
package tdc_patgen_pkg;

    localparam int CODE_W    = 5;
    localparam int PAT_W     = 32;
    localparam int LEVEL_MIN = 1;
    localparam int LEVEL_MAX = 3;

    localparam logic [1:0] MODE_IDLE     = 2'b00;
    localparam logic [1:0] MODE_SINGLE   = 2'b01;
    localparam logic [1:0] MODE_SWEEP    = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_SWEEP  = 2'd2
    } patgen_state_e;

endpackage

// File: rtl/tdc_fine_pattern_gen_if.sv
// rtl/tdc_fine_pattern_gen_if.sv - control/stimulus bundle between a test sequencer and the pattern generator
// Signals: mode/start/abort control, code_in/code_valid/code_ready single-shot handshake,
//          level/dwell operation setup, pattern_out/pattern_valid/expected_code/level_err stimulus,
//          busy/done status. With TDC_PATGEN_BUBBLE_EN: bubble_req in, expected_err out.
// Modports: master = sequencer side, slave = generator side.
interface tdc_fine_pattern_gen_if #(
    parameter int DWELL_W = 8
);
    logic [1:0]         mode;
    logic               start;
    logic               abort;
    logic [4:0]         code_in;
    logic               code_valid;
    logic               code_ready;
    logic [2:0]         level;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        pattern_out;
    logic               pattern_valid;
    logic [4:0]         expected_code;
    logic               level_err;
    logic               busy;
    logic               done;
`ifdef TDC_PATGEN_BUBBLE_EN
    logic               bubble_req;
    logic               expected_err;
`endif

    modport master (
        output mode, start, abort, code_in, code_valid, level, dwell,
        input  code_ready, pattern_out, pattern_valid, expected_code, level_err, busy, done
`ifdef TDC_PATGEN_BUBBLE_EN
        , output bubble_req, input expected_err
`endif
    );

    modport slave (
        input  mode, start, abort, code_in, code_valid, level, dwell,
        output code_ready, pattern_out, pattern_valid, expected_code, level_err, busy, done
`ifdef TDC_PATGEN_BUBBLE_EN
        , input bubble_req, output expected_err
`endif
    );

endinterface

// File: rtl/tdc_fine_pattern_gen_run_decoder.sv
// rtl/tdc_fine_pattern_gen_run_decoder.sv - combinational (code, level) to rotated run-of-ones pattern
// Ports: code_i start tap, level_i run length, bubble_i add isolated bubble one tap past the run,
//        pattern_o 32-tap pattern (zero for illegal level), illegal_o level outside LEVEL_MIN..LEVEL_MAX.
module tdc_run_decoder
    import tdc_patgen_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic [2:0]        level_i,
    input  logic              bubble_i,
    output logic [PAT_W-1:0]  pattern_o,
    output logic              illegal_o
);
    logic [PAT_W-1:0]   run;
    logic [2*PAT_W-1:0] rot;

    always_comb begin
        illegal_o = (level_i < 3'(LEVEL_MIN)) || (level_i > 3'(LEVEL_MAX));
        run = (PAT_W'(1) << level_i) - PAT_W'(1);
        // Bubble leaves one zero tap after the run, then a lone one.
        if (bubble_i && !illegal_o) begin
            run = run | (PAT_W'(1) << (level_i + 3'd1));
        end
        // Upper half of the doubled word shifted left is a rotate-left by code.
        rot = {run, run} << code_i;
        pattern_o = illegal_o ? '0 : rot[2*PAT_W-1:PAT_W];
    end

endmodule

// File: rtl/tdc_fine_pattern_gen.sv
// rtl/tdc_fine_pattern_gen.sv - single-shot / full-sweep fine-code phase pattern generator (optional TDC_PATGEN_BUBBLE_EN)
// Ports: clk, rst_n (async active-low), bus (tdc_fine_pattern_gen_if.slave) carrying mode/start/abort,
//        the code_in/code_valid/code_ready handshake, level/dwell setup and the registered
//        pattern_out/pattern_valid/expected_code/level_err outputs plus busy/done status.
module tdc_fine_pattern_gen
    import tdc_patgen_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tdc_fine_pattern_gen_if.slave  bus
);
    patgen_state_e      state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [2:0]         level_q, level_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [CODE_W-1:0]  dec_code;
    logic [2:0]         dec_level;
    logic               dec_bubble;
    logic [PAT_W-1:0]   dec_pattern;
    logic               dec_illegal;
    logic               is_idle, accept, sweep_go, step_end;

    assign is_idle  = (state_q == ST_IDLE);
    assign accept   = bus.code_valid && bus.code_ready;
    assign sweep_go = is_idle && (bus.mode == MODE_SWEEP) && bus.start;
    assign step_end = (cnt_q == dwell_q);

    // Decoder always prepares the pattern that the next state change will load:
    // the requested code/level while idle, the next sweep code otherwise.
    assign dec_code  = is_idle ? ((bus.mode == MODE_SINGLE) ? bus.code_in : '0)
                               : code_q + CODE_W'(1);
    assign dec_level = is_idle ? bus.level : level_q;

`ifdef TDC_PATGEN_BUBBLE_EN
    logic exp_err_q, exp_err_d;
    assign dec_bubble       = bus.bubble_req;
    assign bus.expected_err = exp_err_q;
`else
    assign dec_bubble = 1'b0;
`endif

    tdc_run_decoder u_run_decoder (
        .code_i    (dec_code),
        .level_i   (dec_level),
        .bubble_i  (dec_bubble),
        .pattern_o (dec_pattern),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        level_d   = level_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        valid_d   = valid_q;
        err_d     = err_q;
        done_d    = 1'b0;
`ifdef TDC_PATGEN_BUBBLE_EN
        exp_err_d = exp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept || sweep_go) begin
                    state_d   = accept ? ST_SINGLE : ST_SWEEP;
                    code_d    = dec_code;
                    level_d   = bus.level;
                    dwell_d   = bus.dwell;
                    cnt_d     = '0;
                    pattern_d = dec_pattern;
                    valid_d   = 1'b1;
                    err_d     = dec_illegal;
`ifdef TDC_PATGEN_BUBBLE_EN
                    exp_err_d = dec_bubble && !dec_illegal;
`endif
                end
            end
            ST_SINGLE: begin
                if (bus.abort || step_end) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_SWEEP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (step_end) begin
                    if (code_q == CODE_W'(PAT_W - 1)) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        code_d    = dec_code;
                        cnt_d     = '0;
                        pattern_d = dec_pattern;
`ifdef TDC_PATGEN_BUBBLE_EN
                        exp_err_d = dec_bubble && !dec_illegal;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            level_q   <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            pattern_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef TDC_PATGEN_BUBBLE_EN
            exp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            level_q   <= level_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            done_q    <= done_d;
`ifdef TDC_PATGEN_BUBBLE_EN
            exp_err_q <= exp_err_d;
`endif
        end
    end

    // Gated by rst_n so the handshake stays closed while reset is held.
    assign bus.code_ready    = rst_n && is_idle && (bus.mode == MODE_SINGLE);
    assign bus.busy          = !is_idle;
    assign bus.pattern_out   = pattern_q;
    assign bus.pattern_valid = valid_q;
    assign bus.expected_code = code_q;
    assign bus.level_err     = err_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_tdc_fine_pattern_gen.sv
// tb/tb_tdc_fine_pattern_gen.sv - scoreboard bench for tdc_fine_pattern_gen
module tb_tdc_fine_pattern_gen;

    logic clk;
    logic rst_n;

    tdc_fine_pattern_gen_if #(.DWELL_W(8)) bus ();

    tdc_fine_pattern_gen #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pat;
        logic [4:0]  code;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   valid_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pat(input int c, input int l);
        logic [31:0] p;
        p = '0;
        if (l >= 1 && l <= 3) begin
            for (int k = 0; k < l; k++) p[(c + k) % 32] = 1'b1;
        end
        return p;
    endfunction

    task automatic push_step(input int c, input int l, input int n);
        exp_t e;
        e.pat  = model_pat(c, l);
        e.code = 5'(c);
        e.err  = (l < 1 || l > 3);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (bus.busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    task automatic do_single(input int c, input int l, input int d);
        @(posedge clk); #1;
        bus.mode = 2'b01; bus.code_in = 5'(c); bus.level = 3'(l);
        bus.dwell = 8'(d); bus.code_valid = 1'b1;
        push_step(c, l, d + 1);
        @(posedge clk); #1;
        bus.code_valid = 1'b0; bus.mode = 2'b00; bus.level = 3'd0; bus.code_in = 5'd0;
        wait_idle(d + 20);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                done_cnt++;
                check_eq("done_valid_low", 64'(bus.pattern_valid), 64'(0));
            end
            if (bus.pattern_valid) begin
                valid_cnt++;
                check_eq("ready_low_busy", 64'(bus.code_ready), 64'(0));
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_valid", 64'(bus.pattern_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("pattern", 64'(bus.pattern_out), 64'(mon_e.pat));
                    check_eq("exp_code", 64'(bus.expected_code), 64'(mon_e.code));
                    check_eq("level_err", 64'(bus.level_err), 64'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

`ifdef TDC_PATGEN_BUBBLE_EN
    initial bus.bubble_req = 1'b0;
`endif

    initial begin
        int d0, v0, n;
        rst_n = 1'b0;
        bus.mode = 2'b01; bus.start = 1'b0; bus.abort = 1'b0;
        bus.code_in = 5'd3; bus.code_valid = 1'b1; bus.level = 3'd1; bus.dwell = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_pattern", 64'(bus.pattern_out), 64'(0));
        check_eq("rst_valid", 64'(bus.pattern_valid), 64'(0));
        check_eq("rst_code", 64'(bus.expected_code), 64'(0));
        check_eq("rst_err", 64'(bus.level_err), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_done", 64'(bus.done), 64'(0));
        check_eq("rst_ready", 64'(bus.code_ready), 64'(0));
        bus.code_valid = 1'b0; bus.mode = 2'b00;
        @(posedge clk); #1 rst_n = 1'b1;

        // Reserved mode behaves as idle.
        @(posedge clk); #1;
        bus.mode = 2'b11; bus.start = 1'b1; bus.code_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mode11_busy", 64'(bus.busy), 64'(0));
        check_eq("mode11_ready", 64'(bus.code_ready), 64'(0));
        bus.mode = 2'b00; bus.start = 1'b0; bus.code_valid = 1'b0;

        // Single shots, including wrap and illegal levels.
        v0 = valid_cnt;
        do_single(0, 1, 0);
        check_eq("single0_cycles", 64'(valid_cnt - v0), 64'(1));
        do_single(30, 3, 1);
        check_eq("hold_pattern", 64'(bus.pattern_out), 64'(32'hC000_0001));
        check_eq("hold_code", 64'(bus.expected_code), 64'(30));
        v0 = valid_cnt;
        do_single(9, 0, 2);
        check_eq("l0_cycles", 64'(valid_cnt - v0), 64'(3));
        check_eq("hold_level_err", 64'(bus.level_err), 64'(1));
        do_single(4, 2, 0);
        do_single(1, 4, 0);
        do_single(31, 2, 0);

        // Full sweep, level 2; code_valid alongside start and a level change mid-sweep are ignored.
        d0 = done_cnt; v0 = valid_cnt;
        @(posedge clk); #1;
        bus.mode = 2'b10; bus.level = 3'd2; bus.dwell = 8'd0; bus.start = 1'b1;
        bus.code_valid = 1'b1; bus.code_in = 5'd7;
        for (int c = 0; c < 32; c++) push_step(c, 2, 1);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.code_valid = 1'b0; bus.level = 3'd3;
        wait_idle(100);
        repeat (2) @(negedge clk);
        check_eq("sweep_cycles", 64'(valid_cnt - v0), 64'(32));
        check_eq("sweep_done", 64'(done_cnt - d0), 64'(1));
        check_eq("sweep_hold", 64'(bus.pattern_out), 64'(32'h8000_0001));

        // Sweep, dwell 3, restart attempt mid-sweep, abort on code 10.
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.mode = 2'b10; bus.level = 3'd1; bus.dwell = 8'd3; bus.start = 1'b1;
        for (int c = 0; c < 10; c++) push_step(c, 1, 4);
        push_step(10, 1, 1);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.start = 1'b1; bus.level = 3'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        n = 0;
        while (!(bus.pattern_valid && bus.expected_code == 5'd10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reach", 64'(bus.expected_code), 64'(10));
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", 64'(bus.pattern_valid), 64'(0));
        check_eq("abort_busy", 64'(bus.busy), 64'(0));
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", 64'(done_cnt - d0), 64'(0));
        check_eq("abort_sb_empty", 64'(sb.size()), 64'(0));

        // code_valid held: second accept only after the first run returns to idle.
        v0 = valid_cnt;
        @(posedge clk); #1;
        bus.mode = 2'b01; bus.code_in = 5'd5; bus.level = 3'd1; bus.dwell = 8'd3;
        bus.code_valid = 1'b1;
        push_step(5, 1, 4);
        push_step(7, 1, 4);
        @(posedge clk); #1 bus.code_in = 5'd7;
        repeat (5) @(posedge clk);
        #1 bus.code_valid = 1'b0; bus.mode = 2'b00;
        wait_idle(30);
        repeat (2) @(negedge clk);
        check_eq("held_cycles", 64'(valid_cnt - v0), 64'(8));

        // Reset pulse mid-sweep clears outputs immediately.
        @(posedge clk); #1;
        bus.mode = 2'b10; bus.level = 3'd2; bus.dwell = 8'd0; bus.start = 1'b1;
        for (int c = 0; c < 32; c++) push_step(c, 2, 1);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pattern", 64'(bus.pattern_out), 64'(0));
        check_eq("arst_valid", 64'(bus.pattern_valid), 64'(0));
        check_eq("arst_code", 64'(bus.expected_code), 64'(0));
        check_eq("arst_busy", 64'(bus.busy), 64'(0));
        check_eq("arst_done", 64'(bus.done), 64'(0));
        sb.delete();
        #4 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", 64'(bus.busy), 64'(0));
        check_eq("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
